// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronise, debounce and validate nickel/dime switches, buffer one coin.
// Optional COIN_ACCEPTOR_STATS_EN adds saturating nickel/dime/reject counters.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       nickel_sw,
  input  logic       dime_sw,
  input  logic       hold,
  output logic [1:0] coin,
  output logic       reject,
  output logic       pending
`ifdef COIN_ACCEPTOR_STATS_EN
  ,
  output logic [CNT_W-1:0] nickel_count,
  output logic [CNT_W-1:0] dime_count,
  output logic [CNT_W-1:0] reject_count
`endif
);

  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, WAIT_RELEASE} state_t;

  state_t     state;
  logic [1:0] sync1, sync2, s;
  logic [1:0] cand, pend_code;
  logic [7:0] cnt;
  logic       pend_v, issue;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {dime_sw, nickel_sw};
      sync2 <= sync1;
    end
  end

  assign s       = sync2;
  assign issue   = pend_v && !hold;
  assign coin    = issue ? pend_code : 2'b00;
  assign pending = pend_v;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      pend_code <= '0;
      pend_v    <= 1'b0;
      reject    <= 1'b0;
    end else begin
      reject <= 1'b0;
      if (issue) pend_v <= 1'b0;
      case (state)
        IDLE: begin
          if (s != 2'b00) begin
            cand  <= s;
            cnt   <= 8'd1;
            state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (s != cand) begin
            state <= IDLE;
          end else if (cnt == LAST) begin
            state <= WAIT_RELEASE;
            cnt   <= '0;
            // A coin issued this very cycle frees the buffer for the new one.
            if (cand == 2'b11 || (pend_v && !issue)) begin
              reject <= 1'b1;
            end else begin
              pend_code <= cand;
              pend_v    <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WAIT_RELEASE: begin
          if (s != 2'b00) begin
            cnt <= '0;
          end else if (cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef COIN_ACCEPTOR_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      nickel_count <= '0;
      dime_count   <= '0;
      reject_count <= '0;
    end else begin
      if (coin == 2'b01 && nickel_count != '1) nickel_count <= nickel_count + 1'b1;
      if (coin == 2'b10 && dime_count != '1)   dime_count   <= dime_count + 1'b1;
      if (reject && reject_count != '1)        reject_count <= reject_count + 1'b1;
    end
  end
`endif

endmodule
